// File: rtl/timer_pkg.sv
// Shared constants and elaboration helpers for the multi-channel timer.
// Latency: none (package only).
// Backpressure: none (package only).
package timer_pkg;

    // Compare write modes, sampled alongside cmp_we.
    localparam logic CMP_ONESHOT  = 1'b0;
    localparam logic CMP_PERIODIC = 1'b1;

    // Clock cycles per time-base tick. A zero tick rate yields 0 so the
    // top level can reject it instead of dividing by zero.
    function automatic int unsigned div_calc(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        if (tick_hz == 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

    // Prescaler width: enough to hold 0..DIV-1, never narrower than one bit.
    function automatic int unsigned presc_w_calc(input int unsigned div);
        if (div <= 2) begin
            return 1;
        end
        return $clog2(div);
    endfunction

endpackage

// File: rtl/timer_cmp_chan.sv
// One compare channel: absolute one-shot or relative periodic match with sticky irq.
// Latency: irq rises on the same edge that the matching now value becomes visible.
// Backpressure: none; write and ack strobes are taken every cycle.
module timer_cmp_chan
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [WIDTH-1:0] now,
    input  logic [WIDTH-1:0] now_next,
    input  logic             cmp_we,
    input  logic             cmp_mode,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             irq_ack,
    output logic             irq
);

    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic             armed_q, armed_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] now_inc;
    logic             match;

    // Only a real increment can match; load and clear never drive inc.
    assign now_inc = now + WIDTH'(1);
    assign match   = inc & armed_q & (now_inc == cmp_q);

    // Next-state: match handling first, then a write overrides cmp/per/armed.
    always_comb begin
        cmp_d   = cmp_q;
        per_d   = per_q;
        armed_d = armed_q;
        irq_d   = irq_q;

        // Set beats ack when both land on the same edge.
        if (match) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end

        if (match) begin
            if (per_q == '0) begin
                armed_d = 1'b0;
            end else begin
                cmp_d = cmp_q + per_q;
            end
        end

        // A write in the same cycle as a match keeps the old-value irq above
        // but fully decides the new compare state.
        if (cmp_we) begin
            armed_d = 1'b1;
            if (cmp_mode == CMP_ONESHOT) begin
                cmp_d = cmp_val;
                per_d = '0;
            end else begin
                cmp_d = now_next + cmp_val;
                per_d = cmp_val;
            end
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_q   <= '0;
            per_q   <= '0;
            armed_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            cmp_q   <= cmp_d;
            per_q   <= per_d;
            armed_q <= armed_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: rtl/timer_multi.sv
// Prescaled WIDTH-bit time base with clear/load, sticky wrap flag and NUM_CMP compare channels.
// Latency: now/tick/ovf/irq are registered; a strobe takes effect on the next edge.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
module timer_multi
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned TICK_HZ = 1000000,
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned NUM_CMP = 2
) (
    input  logic               CLK100MHZ,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   now,
    output logic               tick,
    output logic               ovf,
    input  logic [NUM_CMP-1:0] cmp_we,
    input  logic [NUM_CMP-1:0] cmp_mode,
    input  logic [WIDTH-1:0]   cmp_val,
    input  logic [NUM_CMP-1:0] irq_ack,
    output logic [NUM_CMP-1:0] irq
);

    localparam int unsigned DIV     = div_calc(CLK_HZ, TICK_HZ);
    localparam int unsigned PRESC_W = presc_w_calc(DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

    // Reject clock/tick ratios that are not a whole number of cycles.
    if ((TICK_HZ == 0) || (DIV < 1) ||
        ((CLK_HZ % ((TICK_HZ == 0) ? 1 : TICK_HZ)) != 0)) begin : g_bad_div
        $error("timer_multi: CLK_HZ must be a non-zero multiple of TICK_HZ");
    end

    if ((NUM_CMP < 1) || (NUM_CMP > 8)) begin : g_bad_num_cmp
        $error("timer_multi: NUM_CMP must be in 1..8");
    end

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]   now_q, now_d;
    logic               tick_q, tick_d;
    logic               ovf_q, ovf_d;
    logic               inc;

    // Strobes pre-empt the increment so a clear or load never counts as a tick.
    assign inc = en & (presc_q == PRESC_LAST) & ~clr & ~load;

    // Next-state for prescaler, time base and wrap flag; priority clr > load > inc.
    always_comb begin
        presc_d = presc_q;
        now_d   = now_q;
        ovf_d   = ovf_q;
        tick_d  = 1'b0;

        if (clr) begin
            now_d   = '0;
            presc_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            now_d   = load_val;
            presc_d = '0;
        end else if (inc) begin
            presc_d = '0;
            now_d   = now_q + WIDTH'(1);
            tick_d  = 1'b1;
            if (now_q == '1) begin
                ovf_d = 1'b1;
            end
        end else if (en) begin
            presc_d = presc_q + PRESC_W'(1);
        end
        // en low: prescaler and counter hold, keeping any partial count.
    end

    // Time-base registers with synchronous reset.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            presc_q <= '0;
            now_q   <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            now_q   <= now_d;
            tick_q  <= tick_d;
            ovf_q   <= ovf_d;
        end
    end

    // Each channel sees the current time and the value it takes on this edge,
    // so periodic writes are relative to the time actually in effect.
    for (genvar g = 0; g < NUM_CMP; g++) begin : g_chan
        timer_cmp_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk      (CLK100MHZ),
            .reset    (reset),
            .inc      (inc),
            .now      (now_q),
            .now_next (now_d),
            .cmp_we   (cmp_we[g]),
            .cmp_mode (cmp_mode[g]),
            .cmp_val  (cmp_val),
            .irq_ack  (irq_ack[g]),
            .irq      (irq[g])
        );
    end

    assign now  = now_q;
    assign tick = tick_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: directed scenarios plus a random phase,
// all compared every cycle against a behavioural model of the timer.
module tb_timer_multi;

    localparam int W   = 64;
    localparam int NC  = 2;
    localparam int DIV = 100;

    logic          CLK100MHZ = 1'b0;
    logic          reset, en, clr, load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  now;
    logic          tick, ovf;
    logic [NC-1:0] cmp_we, cmp_mode, irq_ack, irq;
    logic [W-1:0]  cmp_val;

    always #5 CLK100MHZ = ~CLK100MHZ;

    timer_multi #(
        .CLK_HZ  (100000000),
        .TICK_HZ (1000000),
        .WIDTH   (W),
        .NUM_CMP (NC)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .en        (en),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .now       (now),
        .tick      (tick),
        .ovf       (ovf),
        .cmp_we    (cmp_we),
        .cmp_mode  (cmp_mode),
        .cmp_val   (cmp_val),
        .irq_ack   (irq_ack),
        .irq       (irq)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [W-1:0]  m_now;
    int            m_presc;
    logic          m_tick, m_ovf;
    logic [NC-1:0] m_irq;
    logic [W-1:0]  m_cmp [NC];
    logic [W-1:0]  m_per [NC];
    logic          m_armed [NC];

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_update();
        logic          inc;
        logic [W-1:0]  nxt;
        logic [NC-1:0] hit;
        if (reset) begin
            m_now = '0; m_presc = 0; m_tick = 0; m_ovf = 0; m_irq = '0;
            for (int i = 0; i < NC; i++) begin
                m_cmp[i] = '0; m_per[i] = '0; m_armed[i] = 0;
            end
            return;
        end
        inc = en && (m_presc == DIV - 1) && !clr && !load;
        for (int i = 0; i < NC; i++)
            hit[i] = inc && m_armed[i] && (m_now + 1 == m_cmp[i]);
        if (clr)       nxt = '0;
        else if (load) nxt = load_val;
        else if (inc)  nxt = m_now + 1;
        else           nxt = m_now;
        if (clr) m_ovf = 0;
        else if (inc && m_now == {W{1'b1}}) m_ovf = 1;
        if (clr || load) m_presc = 0;
        else if (en)     m_presc = inc ? 0 : m_presc + 1;
        m_tick = inc;
        for (int i = 0; i < NC; i++) begin
            if (hit[i]) m_irq[i] = 1'b1;
            else if (irq_ack[i]) m_irq[i] = 1'b0;
            if (cmp_we[i]) begin
                m_armed[i] = 1;
                if (!cmp_mode[i]) begin
                    m_cmp[i] = cmp_val; m_per[i] = '0;
                end else begin
                    m_cmp[i] = nxt + cmp_val; m_per[i] = cmp_val;
                end
            end else if (hit[i]) begin
                if (m_per[i] == '0) m_armed[i] = 0;
                else m_cmp[i] = m_cmp[i] + m_per[i];
            end
        end
        m_now = nxt;
    endtask

    // One clock: edge, model update, then compare all outputs on the falling edge.
    task automatic step();
        @(posedge CLK100MHZ);
        model_update();
        @(negedge CLK100MHZ);
        chk_eq("now",  now,  m_now);
        chk_eq("tick", tick, m_tick);
        chk_eq("ovf",  ovf,  m_ovf);
        chk_eq("irq",  irq,  m_irq);
    endtask

    task automatic clear_inputs();
        reset = 0; en = 0; clr = 0; load = 0; load_val = '0;
        cmp_we = '0; cmp_mode = '0; cmp_val = '0; irq_ack = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        step();
        chk_eq("rst_now",  now,  0);
        chk_eq("rst_tick", tick, 0);
        chk_eq("rst_ovf",  ovf,  0);
        chk_eq("rst_irq",  irq,  0);
        reset = 0;

        // 1: free run, tick every DIV cycles
        en = 1;
        for (int k = 1; k <= 1000; k++) begin
            step();
            chk_eq("t1_tick", tick, (k % DIV) == 0);
        end
        chk_eq("t1_now", now, 10);

        // 2: pause keeps the partial prescale count
        do_reset();
        en = 1;
        repeat (150) step();
        en = 0;
        repeat (500) step();
        chk_eq("t2_paused_now", now, 1);
        en = 1;
        for (int k = 1; k <= 50; k++) begin
            step();
            chk_eq("t2_tick", tick, k == 50);
        end
        chk_eq("t2_now", now, 2);

        // 3: wrap sets ovf, which holds until clr
        do_reset();
        load = 1; load_val = {W{1'b1}} - 1;
        step();
        load = 0; en = 1;
        for (int k = 1; k <= 200; k++) begin
            step();
            chk_eq("t3_ovf", ovf, k >= 200);
        end
        chk_eq("t3_now", now, 0);
        en = 0;
        repeat (3) step();
        chk_eq("t3_ovf_hold", ovf, 1);
        clr = 1;
        step();
        clr = 0;
        chk_eq("t3_ovf_clr", ovf, 0);

        // 4: one-shot compare, ack, no re-fire; load onto the compare value is silent
        do_reset();
        cmp_we = 2'b01; cmp_mode = 2'b00; cmp_val = 5;
        step();
        cmp_we = '0; en = 1;
        for (int c = 0; c < 3000 && m_now != 20; c++) begin
            irq_ack[0] = (m_now == 7);
            step();
            if (tick && m_now == 5) chk_eq("t4_fire", irq[0], 1);
            if (tick && m_now == 6) chk_eq("t4_sticky", irq[0], 1);
            if (tick && m_now >= 8) chk_eq("t4_norefire", irq[0], 0);
        end
        irq_ack = '0;
        chk_eq("t4_now", now, 20);
        en = 0;
        cmp_we = 2'b01; cmp_mode = 2'b00; cmp_val = 5;
        step();
        cmp_we = '0; load = 1; load_val = 5;
        step();
        load = 0;
        chk_eq("t4_load_noirq", irq[0], 0);
        en = 1;
        repeat (300) step();
        chk_eq("t4_after_load_irq", irq[0], 0);
        chk_eq("t4_after_load_now", now, 8);

        // 5: periodic compare, ack coincident with a match keeps irq set
        do_reset();
        load = 1; load_val = 10;
        step();
        load = 0;
        cmp_we = 2'b10; cmp_mode = 2'b10; cmp_val = 3;
        step();
        cmp_we = '0; en = 1;
        for (int c = 0; c < 1200 && m_now != 20; c++) begin
            irq_ack[1] = (m_now == 13 || m_now == 15 || m_now == 17);
            step();
            if (tick && (m_now == 13 || m_now == 16 || m_now == 19))
                chk_eq("t5_fire", irq[1], 1);
            if (tick && (m_now == 14 || m_now == 18))
                chk_eq("t5_acked", irq[1], 0);
        end
        irq_ack = '0;
        chk_eq("t5_now", now, 20);

        // 6: reset overrides every strobe; clr beats load
        do_reset();
        load = 1; load_val = {W{1'b1}};
        cmp_we = 2'b01; cmp_mode = 2'b00; cmp_val = 0;
        step();
        load = 0; cmp_we = '0; en = 1;
        repeat (150) step();
        chk_eq("t6_pre_ovf", ovf, 1);
        chk_eq("t6_pre_irq", irq, 2'b01);
        reset = 1; clr = 1; load = 1; load_val = 64'h1234;
        cmp_we = 2'b11; cmp_mode = 2'b10; cmp_val = 1;
        step();
        chk_eq("t6_now",  now,  0);
        chk_eq("t6_irq",  irq,  0);
        chk_eq("t6_ovf",  ovf,  0);
        chk_eq("t6_tick", tick, 0);
        clear_inputs();
        en = 1;
        repeat (40) step();
        clr = 1; load = 1; load_val = 64'd123;
        step();
        chk_eq("t6_clr_load", now, 0);
        clear_inputs();

        // Random phase
        for (int c = 0; c < 6000; c++) begin
            reset = ($urandom_range(999) < 3);
            en    = ($urandom_range(9) < 8);
            clr   = ($urandom_range(99) < 1);
            load  = ($urandom_range(99) < 2);
            if ($urandom_range(3) == 0) load_val = {W{1'b1}} - $urandom_range(3);
            else                        load_val = m_now + $urandom_range(5);
            for (int i = 0; i < NC; i++) begin
                cmp_we[i]   = ($urandom_range(99) < 3);
                cmp_mode[i] = $urandom_range(1);
                irq_ack[i]  = ($urandom_range(9) < 1);
            end
            if ($urandom_range(1) == 1) cmp_val = $urandom_range(6);
            else                        cmp_val = m_now + $urandom_range(6, 1);
            step();
        end
        clear_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
Parametrised successor to the free-running microsecond timer. It keeps a WIDTH-bit time base that advances at TICK_HZ, derived from CLK100MHZ by an internal prescaler, with no generated clock. It adds enable, clear, load, an overflow flag and NUM_CMP compare channels. Each channel can be one-shot or periodic and raises a sticky interrupt flag. Software drives it through simple per-cycle strobes from the register interface.

Parameters:
CLK_HZ, 100000000, input clock frequency.
TICK_HZ, 1000000, time-base rate; DIV = CLK_HZ/TICK_HZ. Elaboration error unless CLK_HZ % TICK_HZ == 0 and DIV >= 1.
WIDTH, 64, counter and compare width.
NUM_CMP, 2, number of compare channels (1..8).

Ports:
CLK100MHZ  in  1  clock; the only clock in the block.
reset  in  1  synchronous, active-high reset.
en  in  1  count enable; the prescaler and counter hold while low.
clr  in  1  strobe: now, prescaler and ovf are set to 0.
load  in  1  strobe: now is set to load_val and the prescaler to 0.
load_val  in  WIDTH  value for load.
now  out  WIDTH  current time (registered).
tick  out  1  one-cycle pulse, high in the first cycle a new incremented now is visible.
ovf  out  1  sticky; set when now wraps from all-ones to 0.
cmp_we  in  NUM_CMP  per-channel compare write strobe.
cmp_mode  in  NUM_CMP  sampled with cmp_we: 0 = one-shot/absolute, 1 = periodic/relative.
cmp_val  in  WIDTH  shared compare write data.
irq_ack  in  NUM_CMP  per-channel flag clear.
irq  out  NUM_CMP  sticky match flags.

Behaviour:
- Reset values: now, prescaler, tick, ovf, irq, compare registers, period registers and armed bits are all 0.
- Priority per edge: reset > clr > load > increment.
- Prescaler counts 0..DIV-1 while en=1 and no clr/load.
- inc = en & (presc == DIV-1) & ~clr & ~load.
- On an inc edge: presc <= 0, now <= now+1 (mod 2^WIDTH), tick <= 1. Otherwise tick <= 0.
- DIV == 1 gives inc on every enabled cycle.
- en=0 freezes presc and now. A partial prescale count is preserved across the pause.
- clr: now <= 0, presc <= 0, ovf <= 0; tick stays 0 and no compare is evaluated.
- load: now <= load_val, presc <= 0; ovf is unchanged; no compare is evaluated.
- Wrap: an inc edge with now == all-ones gives now <= 0 and ovf <= 1. ovf holds until clr or reset.
- Compare match on channel i: inc edge & armed[i] & (now+1 == cmp[i]). irq[i] <= 1 on the same edge, so irq and tick rise together.
  - Only increments match. Load/clr landing on cmp[i] never fires.
- One-shot write (cmp_we[i], cmp_mode[i]=0): cmp[i] <= cmp_val, per[i] <= 0, armed[i] <= 1. On match, armed[i] <= 0.
- Periodic write (cmp_mode[i]=1): cmp[i] <= now_next + cmp_val, where now_next is the value now takes on that edge. Also per[i] <= cmp_val, armed[i] <= 1.
  - On match: cmp[i] <= cmp[i] + per[i] (mod 2^WIDTH); stays armed.
  - per[i] == 0 behaves as one-shot.
- irq_ack[i] clears irq[i]. Set wins over ack in the same cycle.
- cmp_we[i] in the same cycle as a match on channel i: the match from the old value still sets irq[i]. The write determines the new cmp/per/armed.
- reset mid-operation: all state returns to reset values on that edge, regardless of the other inputs.

Decomposition:
- Package timer_pkg:
  - function div_calc(CLK_HZ, TICK_HZ);
  - localparam CMP_ONESHOT = 1'b0, CMP_PERIODIC = 1'b1;
  - PRESC_W = $clog2(DIV) (minimum 1).
- Sub-module timer_cmp_chan: one channel (cmp, per, armed, irq logic).
  - Inputs: inc, now, now_next, cmp_we, cmp_mode, cmp_val, irq_ack.
  - Output: irq.
  - Instantiated NUM_CMP times in a generate loop.
- Prescaler, counter and ovf stay in the top level.

Test Plan:
1. Defaults, reset then en=1 for 1000 cycles -> now=10; tick pulses exactly at cycles 100, 200, ..., 1000; no other tick.
2. en=1 for 150 cycles, en=0 for 500, en=1 for 50 -> now=2; the second tick arrives 50 enabled cycles after resume.
3. load with load_val=2^64-2, then en=1 for 200 cycles -> now=0; ovf rises on the wrap edge and stays 1; clr drops it to 0.
4. One-shot cmp0=5 from now=0 -> irq[0] rises with tick at now=5; stays high; irq_ack[0] clears it; no re-fire through now=20. load_val=5 gives no irq.
5. Periodic cmp1, cmp_val=3, written at now=10 -> irq[1] at now=13, 16, 19. Ack after each; an ack coincident with the now=16 match leaves irq[1]=1.
6. reset with clr, load, cmp_we all high mid-count -> next cycle now=0, irq=0, ovf=0, tick=0. clr+load together (no reset) -> now=0.
